msrh_dcache_refill: RTL and testbench
=====================================

Name: msrh_dcache_refill

Overview:
- Miss/refill engine on the write side of the L1 data cache array.
- Accepts one miss address from the LSU miss path and issues a line request to L2.
- Assembles the returned beats into a full line and drives the cache array update interface (valid/addr/be/data) for one cycle.
- Pulses refill-done so waiting LSU pipes replay. One refill outstanding at a time.

Parameters:
- PADDR_W, 56, physical address width.
- LINE_W, 128, cache line width in bits; equals the array data width.
- BEAT_W, 64, L2 response beat width; LINE_W must be a multiple of BEAT_W, with 1 to 8 beats.
- L2_TAG_W, 4, L2 transaction tag width.
- MY_L2_TAG, 4'h2, tag value this block puts on its L2 requests and matches on responses.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_miss_valid  in  1  LSU miss request
- o_miss_ready  out  1  miss accepted when valid&ready
- i_miss_paddr  in  PADDR_W  miss physical address (any byte offset)
- o_l2_req_valid  out  1  L2 line request
- i_l2_req_ready  in  1  L2 accepts request
- o_l2_req_addr  out  PADDR_W  line-aligned (or critical-beat-aligned, see Optional Feature) request address
- o_l2_req_tag  out  L2_TAG_W  always MY_L2_TAG
- i_l2_resp_valid  in  1  L2 response beat valid
- i_l2_resp_tag  in  L2_TAG_W  response tag
- i_l2_resp_data  in  BEAT_W  response beat data
- o_dc_update_valid  out  1  cache array write strobe
- o_dc_update_addr  out  PADDR_W  line-aligned write address
- o_dc_update_be  out  LINE_W/8  byte enables, all ones
- o_dc_update_data  out  LINE_W  assembled line
- o_refill_done  out  1  one-cycle pulse after the array write
- o_refill_paddr  out  PADDR_W  line address of the completed refill
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: FSM=IDLE, beat counter=0, line buffer=0, captured addr=0. All valid/done outputs 0, o_miss_ready=1, addr/data outputs 0.
- FSM states IDLE -> L2_REQ -> L2_RESP -> DC_WRITE -> IDLE.
- IDLE: o_miss_ready=1. On i_miss_valid:
  - capture line address = i_miss_paddr with the low log2(LINE_W/8) bits cleared;
  - capture the critical beat index;
  - go to L2_REQ.
- L2_REQ: o_l2_req_valid=1 with a stable address. Hold until i_l2_req_ready, then go to L2_RESP with the beat counter cleared.
- L2_RESP:
  - Only beats with i_l2_resp_tag==MY_L2_TAG are written into the line buffer. Other tags are ignored with no state change.
  - Beat k is written to line slice [k*BEAT_W +: BEAT_W]. Beat order is given by the Optional Feature.
  - The counter increments per accepted beat. After the last beat (count==LINE_W/BEAT_W-1 accepted), go to DC_WRITE.
- DC_WRITE: o_dc_update_valid=1 for exactly one cycle, with addr/be/data driven from the registers. Next cycle is IDLE.
- o_refill_done pulses in the cycle after DC_WRITE, with o_refill_paddr equal to the written line address. This gives the array one cycle to make the new line readable.
- A new miss may be accepted in the same cycle as the o_refill_done pulse.
- o_miss_ready=0 in every non-IDLE state. A miss held high during a refill is accepted on return to IDLE; a same-line miss is not merged.
- Latency with L2 ready immediately and back-to-back beats: miss accept (cycle 0) -> req (1) -> beats (2..N+1) -> update (N+2) -> done (N+3).
- Responses arriving while in IDLE or L2_REQ are dropped.
- Asynchronous reset mid-refill returns to IDLE immediately. No update or done is issued, and the partial line is discarded.

Optional Feature:
MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN
- Defined: o_l2_req_addr = miss address aligned to BEAT_W. L2 returns the critical beat first, then wraps modulo the beat count. Slot index = (critical_idx + counter) mod beats.
- Undefined: o_l2_req_addr is line-aligned, beats return in order from 0, and slot index = counter.
- o_dc_update_data is identical in both builds.

Test Plan:
- Miss 0x8000_1238, L2 ready, tag 2, beats 0xAAAA_AAAA_AAAA_AAAA then 0xBBBB_BBBB_BBBB_BBBB (feature off) -> req addr 0x8000_1230; update addr 0x8000_1230, be 16'hFFFF, data {BBBB..,AAAA..}; done pulses one cycle after update.
- Same miss with feature on, beats returned B then A -> req addr 0x8000_1238; identical update data.
- Beat with tag 5 interleaved between the two valid beats -> ignored; counter still 1; update uses only tag-2 beats.
- i_l2_req_ready held low 7 cycles -> o_l2_req_valid steady 7 cycles, address unchanged; o_miss_ready stays 0; second miss 0x8000_2000 accepted in the done-pulse cycle.
- Reset asserted after the first beat -> o_busy=0 next edge; no o_dc_update_valid or o_refill_done; a subsequent miss completes normally.
- Response beat in IDLE -> no update, no state change.

Source files
------------

// File: rtl/msrh_dcache_refill.sv
// L1 data-cache refill engine: one outstanding L2 line fetch, beat assembly, one-cycle array write, done pulse.
// Build option: define MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN for critical-beat-first L2 requests.
module msrh_dcache_refill #(
    parameter int                  PADDR_W   = 56,
    parameter int                  LINE_W    = 128,
    parameter int                  BEAT_W    = 64,
    parameter int                  L2_TAG_W  = 4,
    parameter logic [L2_TAG_W-1:0] MY_L2_TAG = 4'h2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_miss_valid,
    output logic                  o_miss_ready,
    input  logic [PADDR_W-1:0]    i_miss_paddr,
    output logic                  o_l2_req_valid,
    input  logic                  i_l2_req_ready,
    output logic [PADDR_W-1:0]    o_l2_req_addr,
    output logic [L2_TAG_W-1:0]   o_l2_req_tag,
    input  logic                  i_l2_resp_valid,
    input  logic [L2_TAG_W-1:0]   i_l2_resp_tag,
    input  logic [BEAT_W-1:0]     i_l2_resp_data,
    output logic                  o_dc_update_valid,
    output logic [PADDR_W-1:0]    o_dc_update_addr,
    output logic [LINE_W/8-1:0]   o_dc_update_be,
    output logic [LINE_W-1:0]     o_dc_update_data,
    output logic                  o_refill_done,
    output logic [PADDR_W-1:0]    o_refill_paddr,
    output logic                  o_busy,
    output logic [1:0]            o_dbg_state
);
    // Handshakes: a transfer happens in a cycle where valid and ready are both high at the rising edge;
    // valid never depends on ready, and request address/tag stay stable while valid waits for ready.

    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int LINE_OFF_W = $clog2(LINE_W / 8);
    localparam int BEAT_OFF_W = $clog2(BEAT_W / 8);
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [PADDR_W-1:0] LINE_MASK = {PADDR_W{1'b1}} << LINE_OFF_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        L2_REQ   = 2'd1,
        L2_RESP  = 2'd2,
        DC_WRITE = 2'd3
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LINE_W-1:0]   line_q;
    logic [PADDR_W-1:0]  line_addr_q;
    logic [PADDR_W-1:0]  req_addr_q;
    logic                miss_ready_q;
    logic                req_valid_q;
    logic                upd_valid_q;
    logic                done_q;
    logic                busy_q;

    logic [CNT_W-1:0]    slot;
    logic                beat_hit;
    logic [PADDR_W-1:0]  miss_line_addr;
    logic [PADDR_W-1:0]  miss_req_addr;

    assign miss_line_addr = i_miss_paddr & LINE_MASK;
    assign beat_hit       = i_l2_resp_valid && (i_l2_resp_tag == MY_L2_TAG);

`ifdef MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN
    localparam logic [PADDR_W-1:0] BEAT_MASK = {PADDR_W{1'b1}} << BEAT_OFF_W;
    logic [CNT_W-1:0] crit_q;
    logic [CNT_W-1:0] miss_crit;

    if (BEATS > 1) begin : g_crit
        assign miss_crit = i_miss_paddr[BEAT_OFF_W +: CNT_W];
    end else begin : g_no_crit
        assign miss_crit = '0;
    end

    assign miss_req_addr = i_miss_paddr & BEAT_MASK;
    // L2 wraps from the critical beat; the beat count is a power of two so the add wraps naturally.
    assign slot          = crit_q + cnt_q;
`else
    assign miss_req_addr = miss_line_addr;
    assign slot          = cnt_q;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            line_addr_q  <= '0;
            req_addr_q   <= '0;
            miss_ready_q <= 1'b1;
            req_valid_q  <= 1'b0;
            upd_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN
            crit_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_miss_valid) begin
                        state_q      <= L2_REQ;
                        line_addr_q  <= miss_line_addr;
                        req_addr_q   <= miss_req_addr;
`ifdef MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN
                        crit_q       <= miss_crit;
`endif
                        miss_ready_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                L2_REQ: begin
                    if (i_l2_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= L2_RESP;
                    end
                end
                L2_RESP: begin
                    if (beat_hit) begin
                        line_q[int'(slot)*BEAT_W +: BEAT_W] <= i_l2_resp_data;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            state_q     <= DC_WRITE;
                            upd_valid_q <= 1'b1;
                        end
                    end
                end
                DC_WRITE: begin
                    // Done follows the write by one cycle so the new line is readable on replay.
                    upd_valid_q  <= 1'b0;
                    done_q       <= 1'b1;
                    miss_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_miss_ready      = miss_ready_q;
    assign o_l2_req_valid    = req_valid_q;
    assign o_l2_req_addr     = req_addr_q;
    assign o_l2_req_tag      = MY_L2_TAG;
    assign o_dc_update_valid = upd_valid_q;
    assign o_dc_update_addr  = line_addr_q;
    assign o_dc_update_be    = '1;
    assign o_dc_update_data  = line_q;
    assign o_refill_done     = done_q;
    assign o_refill_paddr    = line_addr_q;
    assign o_busy            = busy_q;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_msrh_dcache_refill.sv
// Self-checking bench for msrh_dcache_refill: directed misses, scoreboard-checked L2 requests, array updates and done pulses.
`timescale 1ns/1ps
module tb_msrh_dcache_refill;
  localparam int PADDR_W = 56;
  localparam int LINE_W = 128;
  localparam int BEAT_W = 64;
  localparam int L2_TAG_W = 4;
  localparam int BEATS = 2;
  localparam logic [3:0] TAG = 4'h2;

  localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] CC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] DD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] EE = 64'hEEEE_EEEE_EEEE_EEEE;
  localparam logic [63:0] BAD = 64'hDEAD_BEEF_0BAD_F00D;

`ifdef MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN
  localparam logic [55:0] REQ_1238 = 56'h8000_1238;
  localparam logic [55:0] REQ_1008 = 56'h8000_1008;
`else
  localparam logic [55:0] REQ_1238 = 56'h8000_1230;
  localparam logic [55:0] REQ_1008 = 56'h8000_1000;
`endif

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_miss_valid;
  logic o_miss_ready;
  logic [PADDR_W-1:0] i_miss_paddr;
  logic o_l2_req_valid;
  logic i_l2_req_ready;
  logic [PADDR_W-1:0] o_l2_req_addr;
  logic [L2_TAG_W-1:0] o_l2_req_tag;
  logic i_l2_resp_valid;
  logic [L2_TAG_W-1:0] i_l2_resp_tag;
  logic [BEAT_W-1:0] i_l2_resp_data;
  logic o_dc_update_valid;
  logic [PADDR_W-1:0] o_dc_update_addr;
  logic [LINE_W/8-1:0] o_dc_update_be;
  logic [LINE_W-1:0] o_dc_update_data;
  logic o_refill_done;
  logic [PADDR_W-1:0] o_refill_paddr;
  logic o_busy;
  logic [1:0] o_dbg_state;

  msrh_dcache_refill dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_miss_valid(i_miss_valid),
    .o_miss_ready(o_miss_ready),
    .i_miss_paddr(i_miss_paddr),
    .o_l2_req_valid(o_l2_req_valid),
    .i_l2_req_ready(i_l2_req_ready),
    .o_l2_req_addr(o_l2_req_addr),
    .o_l2_req_tag(o_l2_req_tag),
    .i_l2_resp_valid(i_l2_resp_valid),
    .i_l2_resp_tag(i_l2_resp_tag),
    .i_l2_resp_data(i_l2_resp_data),
    .o_dc_update_valid(o_dc_update_valid),
    .o_dc_update_addr(o_dc_update_addr),
    .o_dc_update_be(o_dc_update_be),
    .o_dc_update_data(o_dc_update_data),
    .o_refill_done(o_refill_done),
    .o_refill_paddr(o_refill_paddr),
    .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // Clock/reset block
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scoreboard queues: {line addr, line data} per update, request addresses, expected update cycle (-1 = unchecked)
  logic [PADDR_W+LINE_W-1:0] exp_q[$];
  logic [PADDR_W-1:0] req_q[$];
  logic [PADDR_W-1:0] done_q[$];
  int lat_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: pops and compares whenever the DUT presents a request, update or done pulse
  logic prev_upd = 1'b0;
  always @(negedge i_clk) begin
    logic [PADDR_W+LINE_W-1:0] e;
    int lat;
    if (o_l2_req_valid && i_l2_req_ready) begin
      if (req_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL req_unexpected: got addr %0h want no request", o_l2_req_addr);
      end else begin
        check("req_addr", o_l2_req_addr, req_q.pop_front());
        check("req_tag", o_l2_req_tag, TAG);
      end
    end
    if (o_dc_update_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL update_unexpected: got addr %0h want no update", o_dc_update_addr);
      end else begin
        e = exp_q.pop_front();
        lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
        check("update_addr", o_dc_update_addr, e[PADDR_W+LINE_W-1:LINE_W]);
        check("update_data", o_dc_update_data, e[LINE_W-1:0]);
        check("update_be", o_dc_update_be, 16'hFFFF);
        if (lat >= 0) check("update_latency_cycle", cyc, lat);
        done_q.push_back(e[PADDR_W+LINE_W-1:LINE_W]);
      end
    end
    if (o_refill_done) begin
      check("done_one_cycle_after_update", prev_upd, 1'b1);
      if (done_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got paddr %0h want no done", o_refill_paddr);
      end else begin
        check("done_paddr", o_refill_paddr, done_q.pop_front());
      end
    end else if (prev_upd) begin
      tests++; fails++;
      $display("FAIL done_missing: got done 0 want 1 after update");
    end
    prev_upd = o_dc_update_valid;
  end

  // Driver tasks; inputs change 1ns after the rising edge or at the falling edge
  task automatic issue_miss(input logic [55:0] pa, output int acc_cyc);
    int n;
    n = 0;
    i_miss_valid = 1'b1;
    i_miss_paddr = pa;
    @(negedge i_clk);
    while (!o_miss_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_miss_ready) timeout("miss_accept");
    @(posedge i_clk);
    #1;
    acc_cyc = cyc;
    i_miss_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!(o_l2_req_valid && i_l2_req_ready) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!(o_l2_req_valid && i_l2_req_ready)) timeout("l2_req_handshake");
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] tag, input logic [63:0] data);
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag = tag;
    i_l2_resp_data = data;
    @(posedge i_clk);
    #1;
    i_l2_resp_valid = 1'b0;
  endtask

  // s0/s1 are the data for line slots 0 and 1; L2 order depends on the build
  task automatic send_line(input logic [55:0] pa, input logic [63:0] s0, input logic [63:0] s1,
                           input bit foreign_mid);
    logic [63:0] first;
    logic [63:0] second;
    first = s0;
    second = s1;
`ifdef MSRH_DCACHE_REFILL_CRITICAL_FIRST_EN
    if (pa[3]) begin
      first = s1;
      second = s0;
    end
`else
    if (pa[3] && 1'b0) first = s1;
`endif
    send_beat(TAG, first);
    if (foreign_mid) begin
      send_beat(4'h5, BAD);
      @(negedge i_clk);
      check("foreign_tag_state_resp", o_dbg_state, 2'd2);
      check("foreign_tag_no_update", o_dc_update_valid, 1'b0);
    end
    send_beat(TAG, second);
  endtask

  initial begin
    int acc;
    int n;
    i_reset = 1'b1;
    i_miss_valid = 1'b0;
    i_miss_paddr = '0;
    i_l2_req_ready = 1'b1;
    i_l2_resp_valid = 1'b0;
    i_l2_resp_tag = '0;
    i_l2_resp_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_miss_ready", o_miss_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_state", o_dbg_state, 2'd0);
    check("rst_req_valid", o_l2_req_valid, 1'b0);
    check("rst_req_addr", o_l2_req_addr, 56'h0);
    check("rst_update_valid", o_dc_update_valid, 1'b0);
    check("rst_update_addr", o_dc_update_addr, 56'h0);
    check("rst_update_data", o_dc_update_data, 128'h0);
    check("rst_done", o_refill_done, 1'b0);
    check("rst_refill_paddr", o_refill_paddr, 56'h0);

    // Basic refill, L2 ready immediately, back-to-back beats
    @(posedge i_clk); #1;
    req_q.push_back(REQ_1238);
    exp_q.push_back({56'h8000_1230, BB, AA});
    issue_miss(56'h8000_1238, acc);
    lat_q.push_back(acc + BEATS + 1);
    wait_req();
    send_line(56'h8000_1238, AA, BB, 1'b0);
    repeat (4) @(posedge i_clk); #1;

    // Foreign-tag beat between the two valid beats
    req_q.push_back(REQ_1238);
    exp_q.push_back({56'h8000_1230, BB, AA});
    issue_miss(56'h8000_1238, acc);
    lat_q.push_back(-1);
    wait_req();
    send_line(56'h8000_1238, AA, BB, 1'b1);
    repeat (4) @(posedge i_clk); #1;

    // Request stalled 7 cycles, responses during L2_REQ dropped, queued miss taken in done cycle
    i_l2_req_ready = 1'b0;
    req_q.push_back(REQ_1008);
    exp_q.push_back({56'h8000_1000, DD, CC});
    lat_q.push_back(-1);
    req_q.push_back(56'h8000_2000);
    exp_q.push_back({56'h8000_2000, BB, AA});
    issue_miss(56'h8000_1008, acc);
    i_miss_valid = 1'b1;
    i_miss_paddr = 56'h8000_2000;
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag = TAG;
    i_l2_resp_data = EE;
    for (int k = 0; k < 7; k++) begin
      @(negedge i_clk);
      check("stall_req_valid", o_l2_req_valid, 1'b1);
      check("stall_req_addr", o_l2_req_addr, REQ_1008);
      check("stall_miss_ready", o_miss_ready, 1'b0);
    end
    i_l2_resp_valid = 1'b0;
    i_l2_req_ready = 1'b1;
    wait_req();
    send_line(56'h8000_1008, CC, DD, 1'b0);
    n = 0;
    @(negedge i_clk);
    while (!o_miss_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_miss_ready) timeout("second_miss_ready");
    check("second_miss_in_done_cycle", o_refill_done, 1'b1);
    @(posedge i_clk); #1;
    acc = cyc;
    i_miss_valid = 1'b0;
    lat_q.push_back(acc + BEATS + 1);
    wait_req();
    send_line(56'h8000_2000, AA, BB, 1'b0);
    repeat (4) @(posedge i_clk); #1;

    // Reset after the first beat discards the refill
    req_q.push_back(56'h8000_3000);
    issue_miss(56'h8000_3000, acc);
    wait_req();
    send_beat(TAG, AA);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_state", o_dbg_state, 2'd0);
    check("midrst_update_valid", o_dc_update_valid, 1'b0);
    check("midrst_done", o_refill_done, 1'b0);
    check("midrst_update_data", o_dc_update_data, 128'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    repeat (4) @(posedge i_clk); #1;
    req_q.push_back(REQ_1238);
    exp_q.push_back({56'h8000_1230, DD, CC});
    issue_miss(56'h8000_1238, acc);
    lat_q.push_back(acc + BEATS + 1);
    wait_req();
    send_line(56'h8000_1238, CC, DD, 1'b0);
    repeat (4) @(posedge i_clk); #1;

    // Response beats while idle are dropped
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag = TAG;
    i_l2_resp_data = EE;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("idle_resp_state", o_dbg_state, 2'd0);
      check("idle_resp_busy", o_busy, 1'b0);
      check("idle_resp_miss_ready", o_miss_ready, 1'b1);
    end
    i_l2_resp_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    check("update_queue_drained", exp_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
